sd_host_cmd_phy: RTL
====================

// Module: sd_host_cmd_phy
// PURPOSE
//  Host-side SD CMD-line engine, the counterpart to the device-side platform/PHY adapter.
//  Generates the SD clock from clk and serializes 48-bit commands: start, dir=1, index, arg, CRC7, end.
//  Then waits for and deserializes the device response (R1/R3 48-bit, R2 136-bit) and checks its CRC7.
//  Sits between the host command controller and the io_phy_sd_cmd/i_phy_clk pins of the device under test.
// PARAMETERS
//  CLK_DIV       default 2    clk cycles per SD-clock half period; legal range 1..255
//  RESP_TIMEOUT  default 64   SD-clock rising edges to wait for a response start bit (NCR)
// PORTS
//  clk            in   1    system clock
//  rst            in   1    synchronous, active-high reset
//  i_cmd_stb      in   1    1-cycle pulse: start a command; ignored while o_busy=1
//  i_cmd_index    in   6    command index
//  i_cmd_arg      in   32   command argument
//  i_rsp_type     in   2    0=none, 1=48-bit with CRC, 2=136-bit (R2), 3=48-bit no CRC (R3)
//  o_busy         out  1    high from the cycle after the accepted i_cmd_stb until o_done
//  o_done         out  1    1-cycle completion pulse
//  o_rsp          out  128  response payload: 48-bit -> [31:0]=arg bits, upper bits 0; R2 -> bits 127:8 in [119:0]
//  o_rsp_index    out  6    received index field (48-bit types only; R2 -> 6'h3F)
//  o_timeout      out  1    valid with o_done: no start bit seen within RESP_TIMEOUT
//  o_crc_err      out  1    valid with o_done: received CRC7 mismatch
//  o_sd_clk       out  1    SD clock to the pin
//  o_sd_cmd_dir   out  1    1 = host drives CMD
//  o_sd_cmd_out   out  1    CMD value when driving
//  i_sd_cmd_in    in   1    sampled CMD pin
// BEHAVIOUR
//  Reset: o_busy/o_done/o_timeout/o_crc_err=0, o_rsp=0, o_rsp_index=0, o_sd_clk=0, o_sd_cmd_dir=0, o_sd_cmd_out=1; state IDLE.
//  Clock gen: o_sd_clk toggles every CLK_DIV clk cycles while state!=IDLE; it is held low in IDLE.
//  - A 1-cycle fall_tick / rise_tick strobe accompanies each toggle.
//  Drive CMD on fall_tick; sample i_sd_cmd_in on rise_tick.
//  FSM: IDLE -> TX -> (WAIT_RSP -> RX) -> FIN -> IDLE.
//  - IDLE: on i_cmd_stb, latch index/arg/type, clear the result flags, assert o_busy, build the 40-bit head, go to TX.
//  - TX: the first fall_tick sets o_sd_cmd_dir=1 and the first bit. Sends 48 bits MSB first; CRC7 is computed serially over the first 40 bits.
//  - After the end bit: o_sd_cmd_dir=0 on the next fall_tick. rsp_type 0 -> FIN after 8 more SD clocks (NCC); else -> WAIT_RSP.
//  - WAIT_RSP: count rise_ticks. i_sd_cmd_in==0 -> RX, where the start bit counts as bit 0. At count==RESP_TIMEOUT: o_timeout=1 -> FIN.
//  - RX: shift in 47 (types 1,3) or 135 (type 2) further bits. CRC7 is computed over bits [47:8] (48-bit) or [127:8] (R2).
//  - FIN: o_done=1 for 1 clk, o_busy=0 the same cycle, SD clock stops, return to IDLE.
//  CRC7: polynomial x^7+x^3+1, init 0. Type 3 never sets o_crc_err.
//  Missing end bit (0) on a response is flagged as o_crc_err.
//  i_cmd_stb while busy: ignored, no queueing. rst mid-command: immediate return to reset state, CMD released.
//  o_rsp/o_rsp_index hold their last value until the next accepted command.
// CONFIGURATION
//  SD_HOST_CMD_BUSY_WAIT_EN: when defined, adds i_rsp_busy (in, 1) and i_sd_d0_in (in, 1).
//  - If i_rsp_busy=1 (R1b), after the response FIN is delayed while i_sd_d0_in==0, sampled on rise_tick, with the SD clock running.
//  - The busy wait is bounded by 65535 SD clocks; overrun sets o_timeout.
//  - Undefined: the ports are absent and FIN follows RX directly.
// STRUCTURE
//  Shared include sd_host_defines.v: RSP_NONE/RSP_48/RSP_136/RSP_48_NOCRC codes, CMD_LEN=48, R2_LEN=136, NCC=8, state encodings.
//  Sub-module sd_crc7: clk, rst, i_clear, i_en, i_bit, o_crc[6:0]. One instance for TX and one for RX.
// TESTING
//  CMD0, arg 0, type 0 -> CMD bitstream 48'h400000000095; o_done within 56 SD clocks; no flags set.
//  CMD8 arg 32'h000001AA, type 1; model replies 48'h08000001AA13 after 2 clocks.
//  - TX stream 48'h48000001AA87.
//  - o_rsp[31:0]=32'h000001AA, o_rsp_index=8, o_crc_err=0.
//  CMD55 type 1, no reply -> o_done with o_timeout=1 after RESP_TIMEOUT=64 rise ticks; CMD released.
//  Same as the CMD8 case but the model corrupts one arg bit -> o_crc_err=1; the same corruption with type 3 -> o_crc_err=0.
//  CMD2 type 2, model returns a 136-bit CID with valid CRC -> o_rsp[119:0] matches CID[127:8], o_rsp_index=6'h3F.
//  rst asserted mid-TX, then a new CMD0 -> clean frame, no stale o_done; i_cmd_stb while busy is ignored.

Source files
------------

// File: rtl/sd_host_cmd_phy_pkg.sv
// Shared definitions for the host-side SD CMD-line engine.
//  - rsp_t   : response type codes carried on i_rsp_type
//  - state_t : command FSM state encoding
//  - CMD_LEN / R2_LEN / NCC : frame lengths and post-command clock count
// Optional feature macro used by the slice: SD_HOST_CMD_BUSY_WAIT_EN.
package sd_host_cmd_phy_pkg;

    typedef enum logic [1:0] {
        RSP_NONE     = 2'd0,
        RSP_48       = 2'd1,
        RSP_136      = 2'd2,
        RSP_48_NOCRC = 2'd3
    } rsp_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_WAIT = 3'd2,
        S_RX   = 3'd3,
        S_BUSY = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam int CMD_LEN = 48;
    localparam int R2_LEN  = 136;
    localparam int NCC     = 8;

endpackage

// File: rtl/sd_host_cmd_phy_if.sv
// Command handshake between the host command controller (master) and the
// CMD-line engine (slave).
//  i_cmd_stb/i_cmd_index/i_cmd_arg/i_rsp_type : command request
//  o_busy/o_done                              : progress and completion pulse
//  o_rsp/o_rsp_index/o_timeout/o_crc_err      : response result
//  i_rsp_busy                                 : R1b busy wait (only with SD_HOST_CMD_BUSY_WAIT_EN)
interface sd_host_cmd_phy_if;
    logic         i_cmd_stb;
    logic [5:0]   i_cmd_index;
    logic [31:0]  i_cmd_arg;
    logic [1:0]   i_rsp_type;
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
    logic         i_rsp_busy;
`endif
    logic         o_busy;
    logic         o_done;
    logic [127:0] o_rsp;
    logic [5:0]   o_rsp_index;
    logic         o_timeout;
    logic         o_crc_err;

    modport master (
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
        output i_rsp_busy,
`endif
        output i_cmd_stb, i_cmd_index, i_cmd_arg, i_rsp_type,
        input  o_busy, o_done, o_rsp, o_rsp_index, o_timeout, o_crc_err
    );

    modport slave (
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
        input  i_rsp_busy,
`endif
        input  i_cmd_stb, i_cmd_index, i_cmd_arg, i_rsp_type,
        output o_busy, o_done, o_rsp, o_rsp_index, o_timeout, o_crc_err
    );
endinterface

// File: rtl/sd_host_cmd_phy_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enabled clock, MSB first.
//  clk, rst  : clock, synchronous active-high reset
//  i_clear   : restart the CRC at zero (wins over i_en)
//  i_en      : consume i_bit this cycle
//  i_bit     : data bit
//  o_crc     : running CRC remainder
module sd_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);
    logic fb;

    assign fb = i_bit ^ o_crc[6];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            o_crc <= '0;
        end else if (i_en) begin
            o_crc <= {o_crc[5:3], o_crc[2] ^ fb, o_crc[1:0], fb};
        end
    end
endmodule

// File: rtl/sd_host_cmd_phy.sv
// Host-side SD CMD-line engine: divides clk into the SD clock, serializes a
// 48-bit command (start, dir, index, arg, CRC7, end), then collects and checks
// an R1/R3 (48-bit) or R2 (136-bit) response.
//  clk, rst        : system clock, synchronous active-high reset
//  host            : command handshake (sd_host_cmd_phy_if.slave)
//  o_sd_clk        : SD clock pin
//  o_sd_cmd_dir    : 1 = host drives CMD
//  o_sd_cmd_out    : CMD value while driving
//  i_sd_cmd_in     : sampled CMD pin
//  i_sd_d0_in      : DAT0 busy level (only with SD_HOST_CMD_BUSY_WAIT_EN)
// Parameters: CLK_DIV (clk cycles per SD half period, 1..255),
//             RESP_TIMEOUT (SD rising edges allowed before a response start bit).
//
// state  | meaning
// IDLE   | SD clock parked low, waiting for i_cmd_stb
// TX     | shifting the command out on SD falling edges, then NCC clocks for no-response commands
// WAIT   | CMD released, counting rising edges for the response start bit
// RX     | shifting the response in on SD rising edges
// BUSY   | R1b: waiting for DAT0 to return high
// FIN    | one-cycle completion pulse
module sd_host_cmd_phy
    import sd_host_cmd_phy_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    sd_host_cmd_phy_if.slave        host,
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
    input  logic                    i_sd_d0_in,
`endif
    output logic                    o_sd_clk,
    output logic                    o_sd_cmd_dir,
    output logic                    o_sd_cmd_out,
    input  logic                    i_sd_cmd_in
);
    state_t         state;
    rsp_t           rsp_type;
    logic [7:0]     div_cnt;
    logic           sd_clk;
    logic           run, tick, rise_tick, fall_tick, accept;
    logic [39:0]    tx_sr;
    logic [5:0]     tx_cnt;
    logic [2:0]     crc_sel;
    logic           tx_bit, tx_crc_en;
    logic [6:0]     tx_crc, rx_crc;
    logic [127:0]   rx_sr, rx_next;
    logic [7:0]     rx_cnt, rx_pos, rx_last;
    logic           rx_in_crc, rx_crc_en;
    logic [15:0]    wait_cnt;
    logic           busy, done, timeout, crc_err, cmd_dir, cmd_out;
    logic [127:0]   rsp;
    logic [5:0]     rsp_index;
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
    logic           rsp_busy_q;
`endif

    always_comb begin
        run       = (state == S_TX) || (state == S_WAIT) || (state == S_RX) || (state == S_BUSY);
        tick      = run && (div_cnt == 8'd0);
        rise_tick = tick && !sd_clk;
        fall_tick = tick && sd_clk;
        accept    = (state == S_IDLE) && host.i_cmd_stb;
        // Bits 40..46 of the frame carry the CRC, MSB first.
        crc_sel   = 3'(6'd46 - tx_cnt);
        if (tx_cnt < 6'd40)      tx_bit = tx_sr[39];
        else if (tx_cnt < 6'd47) tx_bit = tx_crc[crc_sel];
        else                     tx_bit = 1'b1;
        tx_crc_en = fall_tick && (state == S_TX) && (tx_cnt < 6'd40);
        // rx_pos is the position of the bit arriving now; the start bit is taken in WAIT as position 0.
        rx_next   = {rx_sr[126:0], i_sd_cmd_in};
        rx_pos    = (state == S_RX) ? rx_cnt : 8'd0;
        rx_last   = (rsp_type == RSP_136) ? 8'(R2_LEN - 1) : 8'(CMD_LEN - 1);
        rx_in_crc = (rsp_type == RSP_136) ? ((rx_pos >= 8'd8) && (rx_pos < 8'd128))
                                          : (rx_pos < 8'd40);
        rx_crc_en = rise_tick && rx_in_crc &&
                    ((state == S_RX) || ((state == S_WAIT) && !i_sd_cmd_in));
    end

    sd_crc7 u_crc_tx (
        .clk     (clk),
        .rst     (rst),
        .i_clear (accept),
        .i_en    (tx_crc_en),
        .i_bit   (tx_bit),
        .o_crc   (tx_crc)
    );

    sd_crc7 u_crc_rx (
        .clk     (clk),
        .rst     (rst),
        .i_clear (accept),
        .i_en    (rx_crc_en),
        .i_bit   (i_sd_cmd_in),
        .o_crc   (rx_crc)
    );

    // SD clock: down-counter reloads every half period while the engine is active.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= 8'(CLK_DIV - 1);
            sd_clk  <= 1'b0;
        end else if (div_cnt == 8'd0) begin
            div_cnt <= 8'(CLK_DIV - 1);
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rsp_type  <= RSP_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            crc_err   <= 1'b0;
            rsp       <= '0;
            rsp_index <= '0;
            cmd_dir   <= 1'b0;
            cmd_out   <= 1'b1;
            tx_sr     <= '0;
            tx_cnt    <= '0;
            rx_sr     <= '0;
            rx_cnt    <= '0;
            wait_cnt  <= '0;
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
            rsp_busy_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host.i_cmd_stb) begin
                        rsp_type <= rsp_t'(host.i_rsp_type);
                        tx_sr    <= {2'b01, host.i_cmd_index, host.i_cmd_arg};
                        tx_cnt   <= '0;
                        busy     <= 1'b1;
                        timeout  <= 1'b0;
                        crc_err  <= 1'b0;
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
                        rsp_busy_q <= host.i_rsp_busy;
`endif
                        state    <= S_TX;
                    end
                end
                S_TX: begin
                    if (fall_tick) begin
                        if (tx_cnt < 6'(CMD_LEN)) begin
                            cmd_dir <= 1'b1;
                            cmd_out <= tx_bit;
                            tx_cnt  <= tx_cnt + 6'd1;
                            if (tx_cnt < 6'd40) tx_sr <= {tx_sr[38:0], 1'b0};
                        end else if (tx_cnt == 6'(CMD_LEN)) begin
                            // First falling edge after the end bit: release CMD.
                            cmd_dir <= 1'b0;
                            cmd_out <= 1'b1;
                            if (rsp_type == RSP_NONE) begin
                                tx_cnt <= tx_cnt + 6'd1;
                            end else begin
                                wait_cnt <= 16'(RESP_TIMEOUT);
                                state    <= S_WAIT;
                            end
                        end else if (tx_cnt == 6'(CMD_LEN + NCC - 1)) begin
                            // NCC clocks counted from the end bit (the release edge is the first).
                            state <= S_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            tx_cnt <= tx_cnt + 6'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (rise_tick) begin
                        if (!i_sd_cmd_in) begin
                            rx_sr  <= rx_next;
                            rx_cnt <= 8'd1;
                            state  <= S_RX;
                        end else if (wait_cnt == 16'd1) begin
                            timeout <= 1'b1;
                            state   <= S_FIN;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt - 16'd1;
                        end
                    end
                end
                S_RX: begin
                    if (rise_tick) begin
                        rx_sr <= rx_next;
                        if (rx_cnt == rx_last) begin
                            // A missing end bit is reported through the CRC flag.
                            crc_err <= (rsp_type != RSP_48_NOCRC) &&
                                       ((rx_next[7:1] != rx_crc) || !rx_next[0]);
                            if (rsp_type == RSP_136) begin
                                rsp       <= {8'd0, rx_next[127:8]};
                                rsp_index <= 6'h3F;
                            end else begin
                                rsp       <= {96'd0, rx_next[39:8]};
                                rsp_index <= rx_next[45:40];
                            end
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
                            if (rsp_busy_q) begin
                                wait_cnt <= 16'hFFFF;
                                state    <= S_BUSY;
                            end else begin
                                state <= S_FIN;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
`else
                            state <= S_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`endif
                        end else begin
                            rx_cnt <= rx_cnt + 8'd1;
                        end
                    end
                end
`ifdef SD_HOST_CMD_BUSY_WAIT_EN
                S_BUSY: begin
                    if (rise_tick) begin
                        if (i_sd_d0_in) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (wait_cnt == 16'd1) begin
                            timeout <= 1'b1;
                            state   <= S_FIN;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt - 16'd1;
                        end
                    end
                end
`endif
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_sd_clk         = sd_clk;
    assign o_sd_cmd_dir     = cmd_dir;
    assign o_sd_cmd_out     = cmd_out;
    assign host.o_busy      = busy;
    assign host.o_done      = done;
    assign host.o_rsp       = rsp;
    assign host.o_rsp_index = rsp_index;
    assign host.o_timeout   = timeout;
    assign host.o_crc_err   = crc_err;

endmodule
